fetch_queue: RTL and testbench

//   Consumer end of the instruction-fetch interface. Captures the {pc, instruction}

---
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fetch_queue.sv | 51 +++++
 tb/tb_fetch_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]             pc_in;
    logic [WIDTH-1:0]             instruction_in;
    logic                         flush;
    logic                         freeze;
    logic                         id_ready;
    logic                         id_valid;
    logic [WIDTH-1:0]             pc_out;
    logic [WIDTH-1:0]             instruction_out;
    logic [$clog2(DEPTH+1)-1:0]   count;
    modport master (
        output pc_in, instruction_in, flush, id_ready,
        input  freeze, id_valid, pc_out, instruction_out, count
    );
    modport slave (
        input  pc_in, instruction_in, flush, id_ready,
        output freeze, id_valid, pc_out, instruction_out, count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instruction} pairs between fetch and decode,
// with freeze back-pressure to fetch and flush of wrong-path entries.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pc_mem  [DEPTH];
    logic [WIDTH-1:0] ins_mem [DEPTH];
    logic             full, push, pop;
    always_comb begin
        full     = count_q == CW'(DEPTH);
        push     = ~full & ~bus.flush;
        pop      = (count_q != '0) & bus.id_ready & ~bus.flush;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        // flush realigns the read side to the write side instead of zeroing pointers
        rd_ptr_d = bus.flush ? wr_ptr_q : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= bus.pc_in;
            ins_mem[wr_ptr_q] <= bus.instruction_in;
        end
    end
    always_comb begin
        bus.freeze          = full;
        bus.count           = count_q;
        bus.id_valid        = count_q != '0;
        bus.pc_out          = bus.id_valid ? pc_mem[rd_ptr_q] : '0;
        bus.instruction_out = bus.id_valid ? ins_mem[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus a wrap sequence checked against a queue model.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(4), .WIDTH(32)) bus();
    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        r;
        logic        f;
        logic        rdy;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        vld;
        logic        frz;
        logic [31:0] pco;
    } vec_t;

    vec_t tbl [23];
    logic [31:0] q [$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic rdy, input logic [31:0] pc);
        rst = r;
        bus.flush = f;
        bus.id_ready = rdy;
        bus.pc_in = pc;
        bus.instruction_in = ins(pc);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string n, input logic [2:0] cnt, input logic vld,
                           input logic frz, input logic [31:0] pco);
        chk({n, ".count"}, 32'(bus.count), 32'(cnt));
        chk({n, ".id_valid"}, 32'(bus.id_valid), 32'(vld));
        chk({n, ".freeze"}, 32'(bus.freeze), 32'(frz));
        chk({n, ".pc_out"}, bus.pc_out, pco);
        chk({n, ".instr_out"}, bus.instruction_out, pco == 0 ? 32'h0 : ins(pco));
    endtask

    initial begin
        // fill 4..16, 20 dropped while frozen
        tbl[0]  = '{0, 0, 0, 32'd4,  3'd1, 1, 0, 32'd4};
        tbl[1]  = '{0, 0, 0, 32'd8,  3'd2, 1, 0, 32'd4};
        tbl[2]  = '{0, 0, 0, 32'd12, 3'd3, 1, 0, 32'd4};
        tbl[3]  = '{0, 0, 0, 32'd16, 3'd4, 1, 1, 32'd4};
        tbl[4]  = '{0, 0, 0, 32'd20, 3'd4, 1, 1, 32'd4};
        // drain: first pop while frozen, then push+pop
        tbl[5]  = '{0, 0, 1, 32'd20, 3'd3, 1, 0, 32'd8};
        tbl[6]  = '{0, 0, 1, 32'd24, 3'd3, 1, 0, 32'd12};
        tbl[7]  = '{0, 0, 1, 32'd28, 3'd3, 1, 0, 32'd16};
        tbl[8]  = '{0, 0, 1, 32'd32, 3'd3, 1, 0, 32'd24};
        // flush with ready high, then next push at head
        tbl[9]  = '{0, 1, 1, 32'h24, 3'd0, 0, 0, 32'd0};
        tbl[10] = '{0, 0, 0, 32'h28, 3'd1, 1, 0, 32'h28};
        // streaming
        tbl[11] = '{0, 0, 1, 32'd44, 3'd1, 1, 0, 32'd44};
        tbl[12] = '{0, 0, 1, 32'd48, 3'd1, 1, 0, 32'd48};
        tbl[13] = '{0, 0, 1, 32'd52, 3'd1, 1, 0, 32'd52};
        // fill again and flush while full
        tbl[14] = '{0, 0, 0, 32'd56, 3'd2, 1, 0, 32'd52};
        tbl[15] = '{0, 0, 0, 32'd60, 3'd3, 1, 0, 32'd52};
        tbl[16] = '{0, 0, 0, 32'd64, 3'd4, 1, 1, 32'd52};
        tbl[17] = '{0, 1, 0, 32'd68, 3'd0, 0, 0, 32'd0};
        tbl[18] = '{0, 0, 0, 32'd72, 3'd1, 1, 0, 32'd72};
        // ready ignored while empty
        tbl[19] = '{0, 1, 1, 32'd76, 3'd0, 0, 0, 32'd0};
        tbl[20] = '{0, 0, 1, 32'd80, 3'd1, 1, 0, 32'd80};
        // reset mid-operation
        tbl[21] = '{1, 0, 0, 32'd84, 3'd0, 0, 0, 32'd0};
        tbl[22] = '{0, 0, 0, 32'd88, 3'd1, 1, 0, 32'd88};

        bus.flush = 0;
        bus.id_ready = 0;
        bus.pc_in = 0;
        bus.instruction_in = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 0, 0, 32'd0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].rdy, tbl[i].pc);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].frz, tbl[i].pco);
        end

        drive(0, 1, 0, 32'h1FC);
        chk_all("wrap_flush", 3'd0, 0, 0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            logic rdy;
            logic [31:0] pc;
            logic do_push, do_pop;
            rdy = (i % 3) != 1;
            pc = 32'h200 + 32'(4 * i);
            do_push = q.size() != 4;
            do_pop = q.size() != 0 && rdy;
            drive(0, 0, rdy, pc);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(pc);
            chk_all($sformatf("wrap%0d", i), 3'(q.size()), q.size() != 0, q.size() == 4,
                    q.size() != 0 ? q[0] : 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [31:0] pc;
            logic do_push;
            pc = 32'h300 + 32'(4 * i);
            do_push = q.size() != 4;
            drive(0, 0, 1, pc);
            if (q.size() != 0) void'(q.pop_front());
            if (do_push) q.push_back(pc);
            chk_all($sformatf("wrapdrain%0d", i), 3'(q.size()), q.size() != 0, q.size() == 4,
                    q.size() != 0 ? q[0] : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
